// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: opcodes, FSM encoding and
// the opcode legality helper.
package alu_pkg;

  localparam logic [2:0] MODE_ADD  = 3'b000;
  localparam logic [2:0] MODE_AND  = 3'b001;
  localparam logic [2:0] MODE_OR   = 3'b010;
  localparam logic [2:0] MODE_XOR  = 3'b011;
  localparam logic [2:0] MODE_XNOR = 3'b100;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  // Opcodes 000..100 are implemented; 101..111 are rejected with Err.
  function automatic logic mode_legal(input logic [2:0] mode);
    return (mode <= MODE_XNOR);
  endfunction

endpackage

// File: rtl/alu_serial_seq_if.sv
// Request/response bundle between a requester and the bit-serial ALU.
//
// Handshake: Start is a one-sided request. It is accepted at a rising edge
// only when Busy is low (IDLE or FIN); OpA/OpB/Mode/CarryIn are captured at
// that same edge. A Start seen while Busy is high is dropped, not queued.
// Completion is signalled by a one-cycle Done pulse (with Err for a rejected
// opcode); Result and Carry then hold until the next accepted Start.
// Dbg_State mirrors the FSM state register for observation.
interface alu_serial_seq_if #(parameter int WIDTH = 8);

  logic             Start;
  logic [2:0]       Mode;
  logic             CarryIn;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic             Busy;
  logic             Done;
  logic             Err;
  logic [WIDTH-1:0] Result;
  logic             Carry;
  logic [1:0]       Dbg_State;

  modport master (
    output Start, Mode, CarryIn, OpA, OpB,
    input  Busy, Done, Err, Result, Carry, Dbg_State
  );

  modport slave (
    input  Start, Mode, CarryIn, OpA, OpB,
    output Busy, Done, Err, Result, Carry, Dbg_State
  );

endinterface

// File: rtl/ALU.sv
// 1-bit ALU cell: full adder for ADD, plain bitwise gates for logic ops.
// Logic ops ignore C_in and drive C_out low; illegal opcodes produce 0.
module ALU
  import alu_pkg::*;
(
  input  logic       A,
  input  logic       B,
  input  logic       C_in,
  input  logic [2:0] Mode,
  output logic       X,
  output logic       C_out
);

  // Per-bit function select
  always_comb begin
    X     = 1'b0;
    C_out = 1'b0;
    case (Mode)
      MODE_ADD: begin
        X     = A ^ B ^ C_in;
        C_out = (A & B) | (C_in & (A ^ B));
      end
      MODE_AND:  X = A & B;
      MODE_OR:   X = A | B;
      MODE_XOR:  X = A ^ B;
      MODE_XNOR: X = ~(A ^ B);
      default: begin
        X     = 1'b0;
        C_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial WIDTH-bit ALU: one ALU cell processes one bit pair per clock,
// LSB first, with the carry held in a flop between bits. Result bits enter
// at the MSB of the result register so that after WIDTH shifts the word is
// in place.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  alu_serial_seq_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_mode;
  logic             r_cf;
  logic [CW-1:0]    r_cnt;
  logic             r_err;
  logic             r_carry;

  logic w_x;
  logic w_cout;
  logic w_accept;
  logic w_last;

  // Busy low is the only acceptance condition for a request.
  assign w_accept = bus.Start && (r_state != RUN);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  ALU u_alu (
    .A     (r_sa[0]),
    .B     (r_sb[0]),
    .C_in  (r_cf),
    .Mode  (r_mode),
    .X     (w_x),
    .C_out (w_cout)
  );

  // Sequencer: accept requests, shift one bit per RUN cycle, pulse FIN.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_result <= '0;
      r_mode   <= MODE_ADD;
      r_cf     <= 1'b0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_result <= {w_x, r_result[WIDTH-1:1]};
          r_sa     <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb     <= {1'b0, r_sb[WIDTH-1:1]};
          r_cf     <= w_cout;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= FIN;
            // The cell already drives C_out low for logic ops; the mode test
            // keeps Carry defined as ADD-only regardless of cell behaviour.
            r_carry <= (r_mode == MODE_ADD) ? w_cout : 1'b0;
          end
        end
        default: begin
          // IDLE and FIN both accept; FIN accepting gives back-to-back ops.
          r_err <= 1'b0;
          if (w_accept) begin
            r_carry <= 1'b0;
            if (mode_legal(bus.Mode)) begin
              r_sa    <= bus.OpA;
              r_sb    <= bus.OpB;
              r_mode  <= bus.Mode;
              r_cf    <= (bus.Mode == MODE_ADD) ? bus.CarryIn : 1'b0;
              r_cnt   <= '0;
              r_state <= RUN;
            end else begin
              r_result <= '0;
              r_err    <= 1'b1;
              r_state  <= FIN;
            end
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.Busy      = (r_state == RUN);
  assign bus.Done      = (r_state == FIN);
  assign bus.Err       = r_err;
  assign bus.Result    = r_result;
  assign bus.Carry     = r_carry;
  assign bus.Dbg_State = r_state;

endmodule
